// File: rtl/double_threshold_unit.sv
// Canny double-threshold stage: max scan, threshold derivation, then per-pixel STRONG/WEAK/0 classification.
// Optional per-class pixel counters are enabled by defining DOUBLE_THRESHOLD_STATS_EN.
module double_threshold_unit #(
    parameter int          HEIGHT        = 5,
    parameter int          WIDTH         = 5,
    parameter logic [7:0]  WEAK_PIXEL    = 8'd75,
    parameter logic [7:0]  STRONG_PIXEL  = 8'd255,
    parameter logic [8:0]  HIGH_RATIO_Q8 = 9'd128,
    parameter logic [8:0]  LOW_RATIO_Q8  = 9'd128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic                          done,
    input  logic [8*HEIGHT*WIDTH-1:0]     img,
    output logic [8*HEIGHT*WIDTH-1:0]     res
`ifdef DOUBLE_THRESHOLD_STATS_EN
    ,
    output logic [$clog2(HEIGHT*WIDTH+1)-1:0] strong_count,
    output logic [$clog2(HEIGHT*WIDTH+1)-1:0] weak_count
`endif
);

    localparam int NPIX  = HEIGHT * WIDTH;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FIND_MAX    = 3'd1,
        COMPUTE_THR = 3'd2,
        CLASSIFY    = 3'd3,
        DONE_STATE  = 3'd4
    } state_t;

    state_t                state_r;
    logic [IDX_W-1:0]      pixel_idx_r;
    logic [7:0]            max_val_r;
    logic [7:0]            high_thr_r;
    logic [7:0]            low_thr_r;
    logic                  done_r;
    logic [8*NPIX-1:0]     res_r;

    logic [7:0]            pix_s;
    logic [7:0]            high_next_s;
    logic [7:0]            low_next_s;
    logic                  is_strong_s;
    logic                  is_weak_s;
    logic [7:0]            class_s;

    // Q0.8 scaling: 17-bit product, drop the 8 fraction bits, keep 8 result bits.
    function automatic logic [7:0] scale_q8(input logic [7:0] v, input logic [8:0] ratio);
        return 8'((17'(v) * 17'(ratio)) >> 8);
    endfunction

    // Current pixel, threshold candidates and the classification of the current pixel.
    always_comb begin
        pix_s       = img[32'(pixel_idx_r) * 8 +: 8];
        high_next_s = scale_q8(max_val_r, HIGH_RATIO_Q8);
        low_next_s  = scale_q8(high_next_s, LOW_RATIO_Q8);
        // A zero pixel is never an edge, even when both thresholds are zero.
        is_strong_s = (pix_s != 8'd0) && (pix_s >= high_thr_r);
        is_weak_s   = (pix_s != 8'd0) && !is_strong_s && (pix_s >= low_thr_r);
        if (is_strong_s) begin
            class_s = STRONG_PIXEL;
        end else if (is_weak_s) begin
            class_s = WEAK_PIXEL;
        end else begin
            class_s = 8'd0;
        end
    end

`ifdef DOUBLE_THRESHOLD_STATS_EN
    localparam int CNT_W = $clog2(NPIX + 1);
    logic [CNT_W-1:0] strong_cnt_r;
    logic [CNT_W-1:0] weak_cnt_r;

    // Per-class counters: cleared when a run starts, advanced while classifying.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strong_cnt_r <= CNT_W'(0);
            weak_cnt_r   <= CNT_W'(0);
        end else begin
            case (state_r)
                IDLE, DONE_STATE: begin
                    if (enable) begin
                        strong_cnt_r <= CNT_W'(0);
                        weak_cnt_r   <= CNT_W'(0);
                    end
                end
                CLASSIFY: begin
                    if (is_strong_s) begin
                        strong_cnt_r <= strong_cnt_r + CNT_W'(1);
                    end
                    if (is_weak_s) begin
                        weak_cnt_r <= weak_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    strong_cnt_r <= strong_cnt_r;
                    weak_cnt_r   <= weak_cnt_r;
                end
            endcase
        end
    end

    assign strong_count = strong_cnt_r;
    assign weak_count   = weak_cnt_r;
`endif

    // Main sequencer: max scan, threshold cycle, classify pass, then hold results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            pixel_idx_r <= {IDX_W{1'b0}};
            max_val_r   <= 8'd0;
            high_thr_r  <= 8'd0;
            low_thr_r   <= 8'd0;
            done_r      <= 1'b0;
            res_r       <= {(8*NPIX){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (enable) begin
                        state_r     <= FIND_MAX;
                        pixel_idx_r <= {IDX_W{1'b0}};
                        max_val_r   <= 8'd0;
                    end
                end
                FIND_MAX: begin
                    if (pix_s > max_val_r) begin
                        max_val_r <= pix_s;
                    end
                    if (pixel_idx_r == LAST_IDX) begin
                        pixel_idx_r <= {IDX_W{1'b0}};
                        state_r     <= COMPUTE_THR;
                    end else begin
                        pixel_idx_r <= pixel_idx_r + IDX_W'(1);
                    end
                end
                COMPUTE_THR: begin
                    high_thr_r <= high_next_s;
                    low_thr_r  <= low_next_s;
                    state_r    <= CLASSIFY;
                end
                CLASSIFY: begin
                    res_r[32'(pixel_idx_r) * 8 +: 8] <= class_s;
                    if (pixel_idx_r == LAST_IDX) begin
                        pixel_idx_r <= {IDX_W{1'b0}};
                        state_r     <= DONE_STATE;
                        done_r      <= 1'b1;
                    end else begin
                        pixel_idx_r <= pixel_idx_r + IDX_W'(1);
                    end
                end
                DONE_STATE: begin
                    if (enable) begin
                        state_r     <= FIND_MAX;
                        done_r      <= 1'b0;
                        pixel_idx_r <= {IDX_W{1'b0}};
                        max_val_r   <= 8'd0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    pixel_idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign done = done_r;
    assign res  = res_r;

endmodule

// File: tb/tb_double_threshold_unit.sv
// Directed bench for double_threshold_unit (5x5, default parameters); define
// DOUBLE_THRESHOLD_STATS_EN to also check the strong/weak counters.
module tb_double_threshold_unit;

    localparam int NPIX = 25;

    logic               clk;
    logic               reset;
    logic               enable;
    logic               done;
    logic [8*NPIX-1:0]  img;
    logic [8*NPIX-1:0]  res;
`ifdef DOUBLE_THRESHOLD_STATS_EN
    logic [4:0]         strong_count;
    logic [4:0]         weak_count;
`endif

    int checks;
    int errors;

    double_threshold_unit dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .done   (done),
        .img    (img),
        .res    (res)
`ifdef DOUBLE_THRESHOLD_STATS_EN
        ,
        .strong_count (strong_count),
        .weak_count   (weak_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse enable for one sampling edge, then count edges until done (bounded).
    task automatic run_to_done(output int edges, output logic done_after_start);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        done_after_start = done;
        @(negedge clk);
        enable = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1) edges++;
        end
        // edges counted the edge that raised done; first loop edge is edge 2 after sampling
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        img    = {(8*NPIX){1'b1}};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || res !== {(8*NPIX){1'b0}}) begin
            errors++;
            $display("FAIL reset_state done=%b res=%h required done=0 res=0", done, res);
        end
`ifdef DOUBLE_THRESHOLD_STATS_EN
        checks++;
        if (strong_count !== 5'd0 || weak_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d required 0/0", strong_count, weak_count);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || res !== {(8*NPIX){1'b0}}) begin
                errors++;
                $display("FAIL idle_hold cycle %0d done=%b res=%h required done=0 res=0", i, done, res);
            end
        end
    endtask

    task automatic load_threshold_image();
        img = {(8*NPIX){1'b0}};
        img[0*8 +: 8] = 8'd200;
        img[1*8 +: 8] = 8'd100;
        img[2*8 +: 8] = 8'd99;
        img[3*8 +: 8] = 8'd50;
        img[4*8 +: 8] = 8'd49;
    endtask

    task automatic test_thresholds();
        int edges;
        logic das;
        logic [8*NPIX-1:0] exp_v;
        load_threshold_image();
        exp_v = {(8*NPIX){1'b0}};
        exp_v[0*8 +: 8] = 8'd255;
        exp_v[1*8 +: 8] = 8'd255;
        exp_v[2*8 +: 8] = 8'd75;
        exp_v[3*8 +: 8] = 8'd75;
        run_to_done(edges, das);
        checks++;
        if (edges !== 51) begin
            errors++;
            $display("FAIL thr_latency got %0d edges required 51", edges);
        end
        checks++;
        if (res !== exp_v) begin
            errors++;
            $display("FAIL thr_result got %h required %h", res, exp_v);
        end
`ifdef DOUBLE_THRESHOLD_STATS_EN
        checks++;
        if (strong_count !== 5'd2 || weak_count !== 5'd2) begin
            errors++;
            $display("FAIL thr_counts got %0d/%0d required 2/2", strong_count, weak_count);
        end
`endif
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || res !== exp_v) begin
            errors++;
            $display("FAIL done_hold done=%b res=%h required done=1 res=%h", done, res, exp_v);
        end
    endtask

    task automatic test_all_zero();
        int edges;
        logic das;
        img = {(8*NPIX){1'b0}};
        run_to_done(edges, das);
        checks++;
        if (edges !== 51) begin
            errors++;
            $display("FAIL zero_latency got %0d edges required 51", edges);
        end
        checks++;
        if (res !== {(8*NPIX){1'b0}}) begin
            errors++;
            $display("FAIL zero_result got %h required 0", res);
        end
`ifdef DOUBLE_THRESHOLD_STATS_EN
        checks++;
        if (strong_count !== 5'd0 || weak_count !== 5'd0) begin
            errors++;
            $display("FAIL zero_counts got %0d/%0d required 0/0", strong_count, weak_count);
        end
`endif
    endtask

    task automatic test_uniform();
        int edges;
        logic das;
        for (int i = 0; i < NPIX; i++) img[i*8 +: 8] = 8'd37;
        run_to_done(edges, das);
        checks++;
        if (res !== {(8*NPIX){1'b1}}) begin
            errors++;
            $display("FAIL uniform_result got %h required all ff", res);
        end
        checks++;
        if (dut.high_thr_r !== 8'd18 || dut.low_thr_r !== 8'd9) begin
            errors++;
            $display("FAIL uniform_thr got %0d/%0d required 18/9", dut.high_thr_r, dut.low_thr_r);
        end
`ifdef DOUBLE_THRESHOLD_STATS_EN
        checks++;
        if (strong_count !== 5'd25 || weak_count !== 5'd0) begin
            errors++;
            $display("FAIL uniform_counts got %0d/%0d required 25/0", strong_count, weak_count);
        end
`endif
    endtask

    task automatic test_restart();
        int edges;
        logic das;
        logic [8*NPIX-1:0] exp_v;
        img = {(8*NPIX){1'b0}};
        img[12*8 +: 8] = 8'd255;
        exp_v = {(8*NPIX){1'b0}};
        exp_v[12*8 +: 8] = 8'd255;
        run_to_done(edges, das);
        checks++;
        if (das !== 1'b0) begin
            errors++;
            $display("FAIL restart_done_drop got done=%b required 0", das);
        end
        checks++;
        if (edges !== 51) begin
            errors++;
            $display("FAIL restart_latency got %0d edges required 51", edges);
        end
        checks++;
        if (res !== exp_v) begin
            errors++;
            $display("FAIL restart_result got %h required %h", res, exp_v);
        end
`ifdef DOUBLE_THRESHOLD_STATS_EN
        checks++;
        if (strong_count !== 5'd1 || weak_count !== 5'd0) begin
            errors++;
            $display("FAIL restart_counts got %0d/%0d required 1/0", strong_count, weak_count);
        end
`endif
    endtask

    task automatic test_enable_ignored();
        int edges;
        logic [8*NPIX-1:0] exp_v;
        load_threshold_image();
        exp_v = {(8*NPIX){1'b0}};
        exp_v[0*8 +: 8] = 8'd255;
        exp_v[1*8 +: 8] = 8'd255;
        exp_v[2*8 +: 8] = 8'd75;
        exp_v[3*8 +: 8] = 8'd75;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        edges = 0;
        // Toggle enable across classify edges 28..34.
        while (done !== 1'b1 && edges < 200) begin
            @(negedge clk);
            enable = (edges >= 27 && edges <= 33) ? ~enable : 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        enable = 1'b0;
        checks++;
        if (edges !== 51) begin
            errors++;
            $display("FAIL toggle_latency got %0d edges required 51", edges);
        end
        checks++;
        if (res !== exp_v) begin
            errors++;
            $display("FAIL toggle_result got %h required %h", res, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int edges;
        logic das;
        logic [8*NPIX-1:0] exp_v;
        for (int i = 0; i < NPIX; i++) img[i*8 +: 8] = 8'd37;
        run_to_done(edges, das);
        load_threshold_image();
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || res !== {(8*NPIX){1'b0}}) begin
            errors++;
            $display("FAIL mid_reset done=%b res=%h required done=0 res=0", done, res);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got done=%b required 0", done);
        end
        exp_v = {(8*NPIX){1'b0}};
        exp_v[0*8 +: 8] = 8'd255;
        exp_v[1*8 +: 8] = 8'd255;
        exp_v[2*8 +: 8] = 8'd75;
        exp_v[3*8 +: 8] = 8'd75;
        run_to_done(edges, das);
        checks++;
        if (edges !== 51 || res !== exp_v) begin
            errors++;
            $display("FAIL fresh_run edges=%0d res=%h required 51 and %h", edges, res, exp_v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enable = 1'b0;
        img    = {(8*NPIX){1'b0}};
        test_reset();
        test_thresholds();
        test_all_zero();
        test_uniform();
        test_restart();
        test_enable_ignored();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/double_threshold_unit.md
Name: double_threshold_unit

Overview:
Canny stage that runs directly before hysteresis. It classifies every pixel of a non-max-suppressed gradient image as STRONG, WEAK or 0, using two thresholds derived from the image maximum. It writes the flat STRONG/WEAK/0 array that the hysteresis stage consumes, with the same enable/done handshake. It is a sequential FSM: one max-scan pass, one threshold cycle, then one classify pass.

Parameters:
HEIGHT, 5, image rows
WIDTH, 5, image columns
WEAK_PIXEL, 8'd75, output code for weak edge
STRONG_PIXEL, 8'd255, output code for strong edge
HIGH_RATIO_Q8, 9'd128, high-threshold ratio in Q0.8 (256 = 1.0), legal range 0..256
LOW_RATIO_Q8, 9'd128, low-threshold ratio (of high threshold) in Q0.8, legal range 0..256

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
enable  in  1  start request, sampled in IDLE/DONE_STATE
done  out  1  result valid, held until restart
img  in  8 x HEIGHT*WIDTH  gradient magnitude image, row-major; held stable while busy
res  out  8 x HEIGHT*WIDTH  classified image (STRONG_PIXEL / WEAK_PIXEL / 0)

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All state is updated on posedge clk.
- Reset: state=IDLE, done=0, pixel_idx=0, max_val=0, high_thr=0, low_thr=0, every res[i]=0.
- States: IDLE, FIND_MAX, COMPUTE_THR, CLASSIFY, DONE_STATE.
- IDLE: done=0. enable=1 -> FIND_MAX, with pixel_idx=0 and max_val=0.
- FIND_MAX: one pixel per cycle. max_val <= max(max_val, img[pixel_idx]); pixel_idx increments. After index H*W-1: pixel_idx=0, next state COMPUTE_THR.
- COMPUTE_THR, 1 cycle: high_thr <= (max_val*HIGH_RATIO_Q8)>>8 and low_thr <= (high_thr_next*LOW_RATIO_Q8)>>8, using 17-bit products truncated to 8 bits. high_thr_next is the high value computed in the same cycle, so there is no extra cycle. Next state CLASSIFY.
- CLASSIFY: one pixel per cycle. For p=img[pixel_idx]:
  - p==0 -> 0.
  - else p>=high_thr -> STRONG_PIXEL.
  - else p>=low_thr -> WEAK_PIXEL.
  - else 0.
  - The result is written to res[pixel_idx]. After index H*W-1: next state DONE_STATE and done<=1 on the same edge.
- Latency: done rises on edge 2*H*W+1 after the edge that sampled enable=1 (51 edges for 5x5).
- DONE_STATE: done and res hold. enable=1 -> FIND_MAX with done<=0, pixel_idx=0, max_val=0.
- enable is ignored in FIND_MAX, COMPUTE_THR and CLASSIFY; no restart mid-run.
- res entries not yet rewritten during a rerun keep their previous-run values until written.
- All-zero image: max_val=0 and thresholds are 0; the p==0 rule forces every res to 0.
- Ratio 256: high_thr=max_val, so only max-valued pixels are STRONG.
- Reset mid-operation returns to the full reset values immediately (asynchronous).
- Illegal state encoding -> IDLE.

Optional Feature:
DOUBLE_THRESHOLD_STATS_EN. When defined, two extra outputs are added:
- strong_count [$clog2(H*W+1)-1:0] and weak_count [$clog2(H*W+1)-1:0].
- Both clear to 0 on reset and on entry to FIND_MAX.
- Each increments per pixel classified STRONG or WEAK respectively during CLASSIFY.
- Both are final when done=1 and hold in DONE_STATE.

When not defined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: assert reset with enable=0 -> done=0, all res=0, no change over 100 cycles.
- Threshold boundaries (5x5, defaults): img[0]=200, img[1]=100, img[2]=99, img[3]=50, img[4]=49, rest 0 -> thresholds 100/50; res[0..4]=255,255,75,75,0, rest 0; done rises 51 edges after enable sampled. With stats: strong_count=2, weak_count=2.
- All-zero image: enable -> done after 51 edges, all res=0. With stats: counts 0/0.
- Uniform image, all 37: high=18, low=9 -> all res=255.
- Restart from DONE_STATE: change img to all 0 except img[12]=255, pulse enable -> done drops next edge; after 51 edges res[12]=255, rest 0.
- Mid-run behaviour:
  - enable toggled during CLASSIFY -> ignored, done timing unchanged.
  - reset asserted at cycle 20 -> done=0, res all 0 immediately; a fresh run after that completes normally.
